sti_deserializer: RTL
=====================

// Module: sti_deserializer
// PURPOSE
//   Serial-to-parallel receiver for the STI link: reassembles 16-bit words from the single-bit
//   so_data/so_valid stream that the STI transmitter sends. Frame length, fill, bit order and
//   byte select follow the transmitter's pi_length/pi_fill/pi_msb/pi_low encoding.
//   Sits at the far end of the link. Feeds a word sink through po_data/po_valid and flags
//   malformed frames.
// PARAMETERS
//   CNT_W    8   width of frame_cnt (counts good frames, wraps)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset (0 = reset)
//   si_data      in   1      serial bit, sampled when si_valid=1
//   si_valid     in   1      bit qualifier; a frame is one unbroken run of N valid cycles
//   si_end       in   1      no further frames; sampled only in IDLE
//   cfg_length   in   2      00=8, 01=16, 10=24, 11=32 bit frame (N)
//   cfg_fill     in   1      24/32: 1 = data in upper 16 frame bits, 0 = data in lower 16
//   cfg_msb      in   1      1 = frame sent MSB first, 0 = LSB first
//   cfg_low      in   1      8-bit only: 1 = byte belongs in po_data[15:8], 0 = po_data[7:0]
//   po_data      out  16     reassembled word, held until next good frame
//   po_valid     out  1      1-cycle pulse, po_data updated the same cycle
//   po_err       out  1      1-cycle pulse: nonzero pad bits or aborted frame
//   po_finish    out  1      sticky; set after si_end, cleared only by reset
//   frame_cnt    out  CNT_W  number of frames completed with po_valid, mod 2^CNT_W
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, bit counter 0, shift register 0.
//   Config latch: cfg_* latched on the first valid bit of a frame and held for the whole
//     frame. Changes to cfg_* mid-frame have no effect.
//   FSM states and transitions:
//     IDLE:
//       si_valid=1 -> RECV, bit counter=1.
//       si_valid=0 and si_end=1 -> FIN.
//       si_valid and si_end together: si_valid wins.
//     RECV:
//       si_valid=1 -> capture the bit. On the Nth bit, go to IDLE and complete the frame.
//       si_valid=0 before N bits -> abort: po_err=1 next cycle, po_valid=0, po_data and
//         frame_cnt unchanged, go to IDLE.
//     FIN: terminal. si_valid and si_end are ignored. po_finish=1 from the cycle after entry.
//   Bit mapping: received bit k (k = 0..N-1) lands in frame position k if msb=0, N-1-k if msb=1.
//     This gives frame word F[N-1:0].
//   Extraction (pad = bits that must be 0):
//     8 : low ? {F[7:0],8'h00} : {8'h00,F[7:0]}; no pad bits.
//     16: F[15:0].
//     24: fill ? F[23:8], pad F[7:0]  :  F[15:0], pad F[23:16].
//     32: fill ? F[31:16], pad F[15:0] :  F[15:0], pad F[31:16].
//   Completion timing:
//     - po_valid and po_data are registered 1 cycle after the Nth bit is sampled.
//     - frame_cnt increments in that same cycle.
//     - If any pad bit is nonzero, po_err pulses in the same cycle as po_valid.
//       The word is still delivered.
//   Back-to-back frames: a valid bit in the cycle right after the Nth bit starts a new frame
//     from IDLE. No gap cycle is required, and zero-gap traffic causes no bit loss.
//   Frame counter: wraps 2^CNT_W-1 -> 0.
//   si_end in RECV: ignored. It is acted on only when sampled in IDLE.
//   Reset mid-frame: the partial frame is discarded immediately. No po_valid or po_err follows.
// TESTING
//   T1: len=16, msb=1, bits of 0xA5C3 sent MSB first
//       -> po_valid=1 one cycle after bit 16; po_data=16'hA5C3; po_err=0; frame_cnt=1.
//   T2: len=8, low=1, msb=0, byte 0x3C sent LSB first
//       -> po_data=16'h3C00.
//       Same with low=0 -> po_data=16'h003C.
//   T3: len=32, fill=1, msb=0, frame 32'h1234_0000
//       -> po_data=16'h1234, po_err=0.
//       Repeat with frame bit 3 set -> po_data=16'h1234 with po_err=1.
//   T4: len=24, fill=0, si_valid drops after 5 bits
//       -> po_err pulse, no po_valid, frame_cnt unchanged.
//       Next full frame 0xBEEF -> po_data=16'hBEEF.
//   T5: three 8-bit frames with zero gap
//       -> three po_valid pulses exactly 8 cycles apart; frame_cnt=3.
//   T6: si_end=1 in IDLE -> po_finish=1 and stays 1.
//       Later si_valid traffic -> no po_valid.
//       reset=0 mid-frame -> all outputs 0.

Source files
------------

// File: rtl/sti_deserializer_if.sv
// STI receive-side bundle: serial input, frame configuration and word-sink outputs.
interface sti_deserializer_if #(
    parameter int CNT_W = 8
);
    logic             si_data;
    logic             si_valid;
    logic             si_end;
    logic [1:0]       cfg_length;
    logic             cfg_fill;
    logic             cfg_msb;
    logic             cfg_low;
    logic [15:0]      po_data;
    logic             po_valid;
    logic             po_err;
    logic             po_finish;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output si_data, si_valid, si_end, cfg_length, cfg_fill, cfg_msb, cfg_low,
        input  po_data, po_valid, po_err, po_finish, frame_cnt
    );

    modport slave (
        input  si_data, si_valid, si_end, cfg_length, cfg_fill, cfg_msb, cfg_low,
        output po_data, po_valid, po_err, po_finish, frame_cnt
    );
endinterface

// File: rtl/sti_deserializer.sv
// STI link receiver: rebuilds 16-bit words from 8/16/24/32-bit serial frames,
// flags nonzero pad bits and aborted frames.
//
// state | meaning
// IDLE  | waiting for the first valid bit of a frame, or for si_end
// RECV  | collecting frame bits; a gap before bit N aborts the frame
// FIN   | link finished; all traffic ignored until reset
module sti_deserializer #(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sti_deserializer_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      frame_q, frame_d;
    logic [1:0]       len_q, len_d;
    logic             fill_q, fill_d;
    logic             msb_q, msb_d;
    logic             low_q, low_d;
    logic [15:0]      po_data_q, po_data_d;
    logic             po_valid_q, po_valid_d;
    logic             po_err_q, po_err_d;
    logic             po_finish_q, po_finish_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic        start, take, abort, last;
    logic [1:0]  len_e;
    logic        msb_e;
    logic [4:0]  bit_k, nm1, pos;
    logic [31:0] frame_nxt;
    logic [16:0] ext;

    // {pad_error, word} for a completed frame
    function automatic logic [16:0] extract(input logic [1:0] len, input logic fill,
                                            input logic low, input logic [31:0] f);
        logic [16:0] r;
        r = '0;
        unique case (len)
            2'b00: r = low ? {1'b0, f[7:0], 8'h00} : {1'b0, 8'h00, f[7:0]};
            2'b01: r = {1'b0, f[15:0]};
            2'b10: r = fill ? {|f[7:0], f[23:8]}   : {|f[23:16], f[15:0]};
            2'b11: r = fill ? {|f[15:0], f[31:16]} : {|f[31:16], f[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // The first bit of a frame uses the live configuration; later bits use the latched copy.
    always_comb begin
        start     = (state_q == IDLE) && bus.si_valid;
        take      = (state_q == RECV) && bus.si_valid;
        abort     = (state_q == RECV) && !bus.si_valid;
        len_e     = start ? bus.cfg_length : len_q;
        msb_e     = start ? bus.cfg_msb    : msb_q;
        bit_k     = start ? 5'd0 : cnt_q;
        nm1       = {len_e, 3'b111};
        pos       = msb_e ? (nm1 - bit_k) : bit_k;
        last      = take && (cnt_q == nm1);
        frame_nxt = start ? 32'h0 : frame_q;
        frame_nxt[pos] = bus.si_data;
        ext       = extract(len_q, fill_q, low_q, frame_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.si_valid)    state_d = RECV;
                else if (bus.si_end) state_d = FIN;
            end
            RECV: if (!bus.si_valid || last) state_d = IDLE;
            FIN:  state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        len_d       = len_q;
        fill_d      = fill_q;
        msb_d       = msb_q;
        low_d       = low_q;
        po_data_d   = po_data_q;
        po_valid_d  = 1'b0;
        po_err_d    = 1'b0;
        po_finish_d = po_finish_q | (state_q == FIN);
        frame_cnt_d = frame_cnt_q;
        if (start) begin
            len_d   = bus.cfg_length;
            fill_d  = bus.cfg_fill;
            msb_d   = bus.cfg_msb;
            low_d   = bus.cfg_low;
            frame_d = frame_nxt;
            cnt_d   = 5'd1;
        end
        if (take) begin
            frame_d = frame_nxt;
            cnt_d   = cnt_q + 5'd1;
        end
        if (last) begin
            cnt_d       = 5'd0;
            po_data_d   = ext[15:0];
            po_valid_d  = 1'b1;
            po_err_d    = ext[16];
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (abort) begin
            cnt_d    = 5'd0;
            po_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            frame_q     <= '0;
            len_q       <= '0;
            fill_q      <= 1'b0;
            msb_q       <= 1'b0;
            low_q       <= 1'b0;
            po_data_q   <= '0;
            po_valid_q  <= 1'b0;
            po_err_q    <= 1'b0;
            po_finish_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            msb_q       <= msb_d;
            low_q       <= low_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            po_err_q    <= po_err_d;
            po_finish_q <= po_finish_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_valid  = po_valid_q;
    assign bus.po_err    = po_err_q;
    assign bus.po_finish = po_finish_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule
